// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared enums for the stream selection/pipeline blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

  // Output stage style used by stream_stage.
  typedef enum logic [1:0] {
    STREAM_PIPELINE_MODE_TRANSPARENT = 2'd0,
    STREAM_PIPELINE_MODE_REGISTERED  = 2'd1,
    STREAM_PIPELINE_MODE_BUFFERED    = 2'd2,
    STREAM_PIPELINE_MODE_ELASTIC     = 2'd3
  } stream_pipeline_mode_t;

  // Arbitration policy used by stream_select.
  typedef enum logic {
    STREAM_SELECT_MODE_ROUND_ROBIN = 1'b0,
    STREAM_SELECT_MODE_ORDERED     = 1'b1
  } stream_select_mode_t;

endpackage
`default_nettype wire

// File: rtl/stream_stage.sv
`default_nettype none
// ============================================================================
// Module      : stream_stage
// Description : Single valid/ready output stage. Transparent wire-through,
//               one-entry register, or two-entry skid buffer whose input
//               ready is purely registered.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_stage
  import stream_pkg::*;
#(
  parameter stream_pipeline_mode_t PIPELINE_MODE = STREAM_PIPELINE_MODE_REGISTERED,
  parameter int                    WIDTH         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  if (PIPELINE_MODE == STREAM_PIPELINE_MODE_TRANSPARENT) begin : g_transparent
    // No storage: clock and reset are not needed here.
    logic w_unused;
    assign w_unused = clk ^ rst;
    assign o_ready  = i_ready;
    assign o_valid  = i_valid;
    assign o_data   = i_data;

  end else if (PIPELINE_MODE == STREAM_PIPELINE_MODE_REGISTERED) begin : g_registered
    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Space is available when empty or when the held beat leaves this cycle.
    assign o_ready = !r_full || i_ready;
    assign o_valid = r_full;
    assign o_data  = r_data;

    // Reload on every edge where space opens; a full register that drains
    // and refills in the same edge keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_full <= 1'b0;
        r_data <= '0;
      end else if (o_ready) begin
        r_full <= i_valid;
        if (i_valid) begin
          r_data <= i_data;
        end
      end
    end

  end else if (PIPELINE_MODE == STREAM_PIPELINE_MODE_BUFFERED) begin : g_buffered
    logic             r_main_valid;
    logic             r_skid_full;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;

    // Ready comes straight from a flop, so upstream never sees i_ready.
    assign o_ready = !r_skid_full;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

    // Main entry feeds the output; the skid entry catches the beat that
    // arrives while the main entry is stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_main_valid <= 1'b0;
        r_skid_full  <= 1'b0;
        r_main_data  <= '0;
        r_skid_data  <= '0;
      end else if (!r_main_valid || i_ready) begin
        if (r_skid_full) begin
          r_main_valid <= 1'b1;
          r_main_data  <= r_skid_data;
          r_skid_full  <= 1'b0;
        end else begin
          r_main_valid <= i_valid;
          if (i_valid) begin
            r_main_data <= i_data;
          end
        end
      end else if (i_valid && !r_skid_full) begin
        r_skid_full <= 1'b1;
        r_skid_data <= i_data;
      end
    end

  end else begin : g_unsupported
    $error("stream_stage: PIPELINE_MODE ELASTIC is not supported");
    logic w_unused;
    assign w_unused = clk ^ rst ^ i_valid ^ i_ready ^ (^i_data);
    assign o_ready  = 1'b0;
    assign o_valid  = 1'b0;
    assign o_data   = '0;
  end

endmodule
`default_nettype wire

// File: rtl/stream_select.sv
`default_nettype none
// ============================================================================
// Module      : stream_select
// Description : N-to-1 valid/ready stream arbiter. Round-robin or strictly
//               ordered selection, source index tagged onto each beat,
//               followed by a configurable output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_select
  import stream_pkg::*;
#(
  parameter int                    PORTS         = 2,
  parameter int                    DATA_WIDTH    = 32,
  parameter stream_select_mode_t   SELECT_MODE   = STREAM_SELECT_MODE_ROUND_ROBIN,
  parameter stream_pipeline_mode_t PIPELINE_MODE = STREAM_PIPELINE_MODE_REGISTERED,
  parameter int                    ID_WIDTH      = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            stream_in_valid,
  output logic [PORTS-1:0]            stream_in_ready,
  input  logic [PORTS*DATA_WIDTH-1:0] stream_in_data,
  output logic                        stream_out_valid,
  input  logic                        stream_out_ready,
  output logic [DATA_WIDTH-1:0]       stream_out_data,
  output logic [ID_WIDTH-1:0]         stream_out_id
);

  localparam int                  c_STAGE_WIDTH = DATA_WIDTH + ID_WIDTH;
  localparam logic [ID_WIDTH-1:0] c_LAST        = ID_WIDTH'(PORTS - 1);

  logic [ID_WIDTH-1:0]      r_ptr;
  logic                     r_lock;
  logic [ID_WIDTH-1:0]      r_lock_id;
  logic [ID_WIDTH-1:0]      w_search;
  logic [ID_WIDTH-1:0]      w_grant;
  logic                     w_sel;
  logic [DATA_WIDTH-1:0]    w_sel_data;
  logic                     w_stage_valid;
  logic                     w_stage_ready;
  logic                     w_in_xfer;
  logic [c_STAGE_WIDTH-1:0] w_stage_in;
  logic [c_STAGE_WIDTH-1:0] w_stage_out;

  // Round-robin search: valid input with the smallest distance above ptr.
  always_comb begin
    int v_dist;
    int v_best;
    v_dist   = 0;
    v_best   = PORTS;
    w_search = r_ptr;
    for (int i = 0; i < PORTS; i++) begin
      v_dist = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + PORTS - int'(r_ptr));
      if (stream_in_valid[i] && (v_dist < v_best)) begin
        v_best   = v_dist;
        w_search = ID_WIDTH'(i);
      end
    end
  end

  // Grant choice (lock overrides policy) and the selected valid/data.
  always_comb begin
    w_grant    = r_ptr;
    w_sel      = 1'b0;
    w_sel_data = '0;
    if (r_lock) begin
      w_grant = r_lock_id;
    end else if (SELECT_MODE == STREAM_SELECT_MODE_ORDERED) begin
      w_grant = r_ptr;
    end else begin
      w_grant = w_search;
    end
    for (int i = 0; i < PORTS; i++) begin
      if (w_grant == ID_WIDTH'(i)) begin
        w_sel      = stream_in_valid[i];
        w_sel_data = stream_in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Only the granted input sees ready, and nothing is accepted during reset.
  always_comb begin
    stream_in_ready = '0;
    for (int i = 0; i < PORTS; i++) begin
      stream_in_ready[i] = w_stage_ready && w_sel && !rst && (w_grant == ID_WIDTH'(i));
    end
  end

  assign w_stage_valid = w_sel && !rst;
  assign w_in_xfer     = w_stage_valid && w_stage_ready;
  assign w_stage_in    = w_stage_valid ? {w_grant, w_sel_data} : '0;

  // Pointer advances past the granted input on every input transfer; the
  // lock freezes the grant while a transparent output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else begin
      if (w_in_xfer) begin
        r_ptr <= (w_grant == c_LAST) ? '0 : w_grant + 1'b1;
      end
      if (PIPELINE_MODE == STREAM_PIPELINE_MODE_TRANSPARENT) begin
        if (stream_out_valid && !stream_out_ready) begin
          r_lock    <= 1'b1;
          r_lock_id <= w_grant;
        end else if (stream_out_valid && stream_out_ready) begin
          r_lock <= 1'b0;
        end
      end
    end
  end

  stream_stage #(
    .PIPELINE_MODE (PIPELINE_MODE),
    .WIDTH         (c_STAGE_WIDTH)
  ) u_stage (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_stage_valid),
    .o_ready (w_stage_ready),
    .i_data  (w_stage_in),
    .o_valid (stream_out_valid),
    .i_ready (stream_out_ready),
    .o_data  (w_stage_out)
  );

  assign {stream_out_id, stream_out_data} = w_stage_out;

endmodule
`default_nettype wire

// File: tb/tb_stream_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_select
// Description : Self-checking bench for stream_select: vector table for
//               round-robin/ordered selection, hand sequences for the
//               transparent grant lock and mid-stream reset, and a random
//               scoreboard run on the buffered stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_select;
  import stream_pkg::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // A: round-robin, 4 ports, registered
  logic [3:0]      a_valid, a_ready;
  logic [4*DW-1:0] a_data;
  logic            a_ovalid, a_oready;
  logic [DW-1:0]   a_odata;
  logic [1:0]      a_oid;
  // B: ordered, 3 ports, registered
  logic [2:0]      b_valid, b_ready;
  logic [3*DW-1:0] b_data;
  logic            b_ovalid, b_oready;
  logic [DW-1:0]   b_odata;
  logic [1:0]      b_oid;
  // C: round-robin, 4 ports, transparent
  logic [3:0]      c_valid, c_ready;
  logic [4*DW-1:0] c_data;
  logic            c_ovalid, c_oready;
  logic [DW-1:0]   c_odata;
  logic [1:0]      c_oid;
  // D: round-robin, 3 ports, buffered
  logic [2:0]      d_valid, d_ready;
  logic [3*DW-1:0] d_data;
  logic            d_ovalid, d_oready;
  logic [DW-1:0]   d_odata;
  logic [1:0]      d_oid;

  stream_select #(.PORTS(4), .DATA_WIDTH(DW), .SELECT_MODE(STREAM_SELECT_MODE_ROUND_ROBIN),
                  .PIPELINE_MODE(STREAM_PIPELINE_MODE_REGISTERED)) u_a (
    .clk(clk), .rst(rst), .stream_in_valid(a_valid), .stream_in_ready(a_ready),
    .stream_in_data(a_data), .stream_out_valid(a_ovalid), .stream_out_ready(a_oready),
    .stream_out_data(a_odata), .stream_out_id(a_oid));

  stream_select #(.PORTS(3), .DATA_WIDTH(DW), .SELECT_MODE(STREAM_SELECT_MODE_ORDERED),
                  .PIPELINE_MODE(STREAM_PIPELINE_MODE_REGISTERED)) u_b (
    .clk(clk), .rst(rst), .stream_in_valid(b_valid), .stream_in_ready(b_ready),
    .stream_in_data(b_data), .stream_out_valid(b_ovalid), .stream_out_ready(b_oready),
    .stream_out_data(b_odata), .stream_out_id(b_oid));

  stream_select #(.PORTS(4), .DATA_WIDTH(DW), .SELECT_MODE(STREAM_SELECT_MODE_ROUND_ROBIN),
                  .PIPELINE_MODE(STREAM_PIPELINE_MODE_TRANSPARENT)) u_c (
    .clk(clk), .rst(rst), .stream_in_valid(c_valid), .stream_in_ready(c_ready),
    .stream_in_data(c_data), .stream_out_valid(c_ovalid), .stream_out_ready(c_oready),
    .stream_out_data(c_odata), .stream_out_id(c_oid));

  stream_select #(.PORTS(3), .DATA_WIDTH(DW), .SELECT_MODE(STREAM_SELECT_MODE_ROUND_ROBIN),
                  .PIPELINE_MODE(STREAM_PIPELINE_MODE_BUFFERED)) u_d (
    .clk(clk), .rst(rst), .stream_in_valid(d_valid), .stream_in_ready(d_ready),
    .stream_in_data(d_data), .stream_out_valid(d_ovalid), .stream_out_ready(d_oready),
    .stream_out_data(d_odata), .stream_out_id(d_oid));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Input transfers seen on the transparent instance.
  int c_xfer_any = 0;
  int c_xfer_2   = 0;
  always @(posedge clk) begin
    if ((c_valid & c_ready) != 4'b0000) c_xfer_any++;
    if (c_valid[2] && c_ready[2]) c_xfer_2++;
  end

  typedef struct {
    bit         dut;      // 0 = A (round-robin), 1 = B (ordered)
    logic [3:0] valid;
    logic [3:0] exp_rdy;  // ready pattern before the edge
    bit         exp_v;    // out_valid after the edge
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[21];

  // Random-run scoreboard state
  int quota[3];
  int sent[3];
  int rcvd[3];
  int total_rcvd;
  int mptr;
  int cyc;
  int exp_g;
  int port;
  logic [2:0] xfer;
  logic [2:0] rdy_snap;

  initial begin
    // Round-robin from ptr 0 with all valid, then only 1 and 3 valid.
    vecs[0]  = '{0, 4'b1111, 4'b0001, 1, 2'd0};
    vecs[1]  = '{0, 4'b1111, 4'b0010, 1, 2'd1};
    vecs[2]  = '{0, 4'b1111, 4'b0100, 1, 2'd2};
    vecs[3]  = '{0, 4'b1111, 4'b1000, 1, 2'd3};
    vecs[4]  = '{0, 4'b1111, 4'b0001, 1, 2'd0};
    vecs[5]  = '{0, 4'b1111, 4'b0010, 1, 2'd1};
    vecs[6]  = '{0, 4'b1010, 4'b1000, 1, 2'd3};
    vecs[7]  = '{0, 4'b1010, 4'b0010, 1, 2'd1};
    vecs[8]  = '{0, 4'b1010, 4'b1000, 1, 2'd3};
    vecs[9]  = '{0, 4'b1010, 4'b0010, 1, 2'd1};
    vecs[10] = '{0, 4'b0000, 4'b0000, 0, 2'd0};
    vecs[11] = '{0, 4'b0001, 4'b0001, 1, 2'd0};
    // Ordered: input 1 withheld for 5 cycles stalls everything behind it.
    vecs[12] = '{1, 4'b0101, 4'b0001, 1, 2'd0};
    vecs[13] = '{1, 4'b0101, 4'b0000, 0, 2'd0};
    vecs[14] = '{1, 4'b0101, 4'b0000, 0, 2'd0};
    vecs[15] = '{1, 4'b0101, 4'b0000, 0, 2'd0};
    vecs[16] = '{1, 4'b0101, 4'b0000, 0, 2'd0};
    vecs[17] = '{1, 4'b0101, 4'b0000, 0, 2'd0};
    vecs[18] = '{1, 4'b0111, 4'b0010, 1, 2'd1};
    vecs[19] = '{1, 4'b0111, 4'b0100, 1, 2'd2};
    vecs[20] = '{1, 4'b0111, 4'b0001, 1, 2'd0};

    for (int i = 0; i < 4; i++) begin
      a_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      c_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);
    end
    for (int i = 0; i < 3; i++) b_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);
    d_data   = '0;
    rst      = 1'b1;
    a_valid  = 4'b1111;  // valid during reset must not be accepted
    b_valid  = '0;
    c_valid  = '0;
    d_valid  = '0;
    a_oready = 1'b1;
    b_oready = 1'b1;
    c_oready = 1'b0;
    d_oready = 1'b0;

    // ---- reset state ----
    @(posedge clk); @(posedge clk); #1;
    check("rst_a_ready", a_ready, 4'b0000);
    check("rst_a_ovalid", a_ovalid, 1'b0);
    check("rst_a_odata", a_odata, 32'h0);
    check("rst_a_oid", a_oid, 2'd0);
    check("rst_b_ovalid", b_ovalid, 1'b0);
    check("rst_c_ovalid", c_ovalid, 1'b0);
    check("rst_d_ovalid", d_ovalid, 1'b0);
    check("rst_d_odata", d_odata, 32'h0);
    rst = 1'b0;

    // ---- vector table ----
    for (int n = 0; n < 21; n++) begin
      if (vecs[n].dut == 1'b0) begin
        a_valid = vecs[n].valid;
        b_valid = '0;
      end else begin
        a_valid = '0;
        b_valid = vecs[n].valid[2:0];
      end
      #1;
      check($sformatf("vec%0d_ready", n), vecs[n].dut ? {1'b0, b_ready} : a_ready, vecs[n].exp_rdy);
      @(posedge clk); #1;
      check($sformatf("vec%0d_ovalid", n), vecs[n].dut ? b_ovalid : a_ovalid, vecs[n].exp_v);
      if (vecs[n].exp_v) begin
        check($sformatf("vec%0d_oid", n), vecs[n].dut ? b_oid : a_oid, vecs[n].exp_id);
        check($sformatf("vec%0d_odata", n), vecs[n].dut ? b_odata : a_odata,
              32'hD000_0000 + 32'(vecs[n].exp_id));
      end
    end
    a_valid = '0;
    b_valid = '0;

    // ---- transparent: stalled output keeps its beat despite a higher-priority input ----
    c_oready = 1'b0;
    c_valid  = 4'b0100;
    #1;
    check("tr_first_valid", c_ovalid, 1'b1);
    check("tr_first_id", c_oid, 2'd2);
    check("tr_first_ready", c_ready, 4'b0000);
    @(posedge clk); #1;
    c_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("tr_hold%0d_id", k), c_oid, 2'd2);
      check($sformatf("tr_hold%0d_data", k), c_odata, 32'hD000_0002);
      @(posedge clk); #1;
    end
    c_oready = 1'b1;
    #1;
    check("tr_release_ready", c_ready, 4'b0100);
    check("tr_release_id", c_oid, 2'd2);
    @(posedge clk); #1;
    c_valid = 4'b0001;
    #1;
    check("tr_xfer_port2", c_xfer_2, 1);
    check("tr_xfer_total", c_xfer_any, 1);
    check("tr_next_id", c_oid, 2'd0);
    @(posedge clk); #1;
    c_valid  = '0;
    c_oready = 1'b0;

    // ---- buffered: random ready, per-port sequence scoreboard ----
    quota[0] = 334; quota[1] = 333; quota[2] = 333;
    for (int p = 0; p < 3; p++) begin
      sent[p] = 0;
      rcvd[p] = 0;
    end
    total_rcvd = 0;
    mptr = 0;
    cyc  = 0;
    while (total_rcvd < 1000 && cyc < 20000) begin
      for (int p = 0; p < 3; p++) begin
        if (!d_valid[p] && sent[p] < quota[p] && $urandom_range(0, 1) == 1) begin
          d_valid[p] = 1'b1;
          d_data[p*DW +: DW] = {8'(p), 24'(sent[p])};
        end
      end
      d_oready = ($urandom_range(0, 1) == 1);
      #1;
      rdy_snap = d_ready;
      d_oready = !d_oready;
      #1;
      check("buf_ready_indep", d_ready, rdy_snap);
      d_oready = !d_oready;
      #1;
      exp_g = -1;
      for (int k = 0; k < 3; k++) begin
        if (exp_g < 0 && d_valid[(mptr + k) % 3]) exp_g = (mptr + k) % 3;
      end
      if (d_ready != 3'b000) begin
        check("buf_grant", d_ready, (exp_g < 0) ? 64'd0 : (64'd1 << exp_g));
      end
      xfer = d_valid & d_ready;
      if (d_ovalid && d_oready) begin
        port = int'(d_odata[31:24]);
        check("buf_port_tag", d_oid, port);
        if (port < 3) begin
          check("buf_seq", d_odata[23:0], 24'(rcvd[port]));
          rcvd[port]++;
        end
        total_rcvd++;
      end
      @(posedge clk); #1;
      for (int p = 0; p < 3; p++) begin
        if (xfer[p]) begin
          sent[p]++;
          d_valid[p] = 1'b0;
          mptr = (p + 1) % 3;
        end
      end
      cyc++;
    end
    check("buf_total", total_rcvd, 1000);
    for (int p = 0; p < 3; p++) check($sformatf("buf_rcvd_p%0d", p), rcvd[p], quota[p]);

    // ---- buffered: reset with two beats held ----
    d_oready = 1'b0;
    d_valid  = 3'b111;
    for (int p = 0; p < 3; p++) d_data[p*DW +: DW] = 32'hEEEE_0000 + 32'(p);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstmid_full_valid", d_ovalid, 1'b1);
    check("rstmid_full_ready", d_ready, 3'b000);
    rst = 1'b1;
    #1;
    check("rstmid_async_valid", d_ovalid, 1'b0);
    check("rstmid_async_data", d_odata, 32'h0);
    @(posedge clk); #1;
    rst      = 1'b0;
    d_valid  = 3'b110;
    d_oready = 1'b1;
    #1;
    check("rstmid_grant", d_ready, 3'b010);
    @(posedge clk); #1;
    check("rstmid_out_valid", d_ovalid, 1'b1);
    check("rstmid_out_id", d_oid, 2'd1);
    check("rstmid_out_data", d_odata, 32'hEEEE_0001);
    d_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
